// File: rtl/seq_binary_to_bcd.sv
// rtl/seq_binary_to_bcd.sv - multi-cycle shift-add-3 binary-to-BCD converter with valid/ready handshakes
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input, magnitude converted, sign on bcd_neg)
module seq_binary_to_bcd #(
  parameter int BIN_WIDTH  = 16,
  parameter int BCD_DIGITS = 5,
  parameter int CNT_WIDTH  = $clog2(BIN_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_WIDTH-1:0]    binary_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    bcd_ovf,
  output logic                    bcd_neg,
  output logic                    busy
);

  localparam int BCD_W = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;
  logic                 bcd_ovf_q, bcd_ovf_d;
  logic                 busy_q, busy_d;

  logic [BIN_WIDTH-1:0] load_mag;
  logic [BCD_W-1:0]     adj_bcd;
  logic [BCD_W-1:0]     shift_bcd;
  logic [BIN_WIDTH-1:0] shift_bin;
  logic                 shift_carry;

`ifdef BIN2BCD_SIGNED_EN
  logic load_neg;
  logic neg_q, neg_d;
  logic bcd_neg_q, bcd_neg_d;

  // The most negative value negates to 2^(BIN_WIDTH-1), which still fits unsigned in BIN_WIDTH bits.
  assign load_neg = binary_in[BIN_WIDTH-1];
  assign load_mag = load_neg ? (~binary_in + BIN_WIDTH'(1)) : binary_in;
  assign bcd_neg  = bcd_neg_q;
`else
  assign load_mag = binary_in;
  assign bcd_neg  = 1'b0;
`endif

  always_comb begin
    adj_bcd = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_bcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_bcd[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // A bit leaving the top digit means the true value needs more digits than we keep.
  assign shift_carry = adj_bcd[BCD_W-1];
  assign shift_bcd   = {adj_bcd[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
  assign shift_bin   = {bin_q[BIN_WIDTH-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    bcd_out_d = bcd_out_q;
    bcd_ovf_d = bcd_ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    neg_d     = neg_q;
    bcd_neg_d = bcd_neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
          bin_d   = load_mag;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_WIDTH'(BIN_WIDTH);
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = load_neg;
`endif
        end
      end
      S_SHIFT: begin
        bin_d = shift_bin;
        bcd_d = shift_bcd;
        ovf_d = ovf_q | shift_carry;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d   = S_DONE;
          bcd_out_d = shift_bcd;
          bcd_ovf_d = ovf_q | shift_carry;
`ifdef BIN2BCD_SIGNED_EN
          bcd_neg_d = neg_q;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_out_q <= '0;
      bcd_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      bcd_out_q <= bcd_out_d;
      bcd_ovf_q <= bcd_ovf_d;
      busy_q    <= busy_d;
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      bcd_neg_q <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      bcd_neg_q <= bcd_neg_d;
    end
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bcd_out   = bcd_out_q;
  assign bcd_ovf   = bcd_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb/tb_seq_binary_to_bcd.sv - checks three converter configurations against an arithmetic model
module tb_seq_binary_to_bcd;

  logic clk;
  logic rst_n;
  logic        iv[3];
  logic [15:0] bin[3];
  logic        ordy[3];

  logic        ir[3], ov[3], ovf[3], ng[3], bz[3];
  logic [19:0] bo[3];

  logic        ir0, ov0, ovf0, ng0, bz0;
  logic        ir1, ov1, ovf1, ng1, bz1;
  logic        ir2, ov2, ovf2, ng2, bz2;
  logic [19:0] bo0;
  logic [15:0] bo1;
  logic [7:0]  bo2;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  seq_binary_to_bcd #(.BIN_WIDTH(16), .BCD_DIGITS(5)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .binary_in(bin[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .bcd_out(bo0), .bcd_ovf(ovf0), .bcd_neg(ng0), .busy(bz0));

  seq_binary_to_bcd #(.BIN_WIDTH(16), .BCD_DIGITS(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .binary_in(bin[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .bcd_out(bo1), .bcd_ovf(ovf1), .bcd_neg(ng1), .busy(bz1));

  seq_binary_to_bcd #(.BIN_WIDTH(5), .BCD_DIGITS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .binary_in(bin[2][4:0]),
    .out_valid(ov2), .out_ready(ordy[2]), .bcd_out(bo2), .bcd_ovf(ovf2), .bcd_neg(ng2), .busy(bz2));

  always_comb begin
    ir[0] = ir0; ov[0] = ov0; ovf[0] = ovf0; ng[0] = ng0; bz[0] = bz0; bo[0] = bo0;
    ir[1] = ir1; ov[1] = ov1; ovf[1] = ovf1; ng[1] = ng1; bz[1] = bz1; bo[1] = {4'b0, bo1};
    ir[2] = ir2; ov[2] = ov2; ovf[2] = ovf2; ng[2] = ng2; bz[2] = bz2; bo[2] = {12'b0, bo2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int i);
    return (i == 2) ? 5 : 16;
  endfunction

  function automatic int dof(input int i);
    return (i == 0) ? 5 : ((i == 1) ? 4 : 2);
  endfunction

  function automatic int pow10(input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] to_bcd(input int v, input int d);
    logic [19:0] r = '0;
    int t = v;
    for (int k = 0; k < 5; k++) begin
      if (k < d) r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int magof(input logic [15:0] b, input int w);
    int raw = int'(b) & ((1 << w) - 1);
`ifdef BIN2BCD_SIGNED_EN
    if (raw >= (1 << (w - 1))) return (1 << w) - raw;
`endif
    return raw;
  endfunction

  function automatic bit negof(input logic [15:0] b, input int w);
`ifdef BIN2BCD_SIGNED_EN
    return b[w-1];
`else
    return (b[0] & 1'b0);
`endif
  endfunction

  // Transaction-level model: pending word, cycles since accept, last published result.
  bit          m_pend[3];
  int          m_age[3];
  int          m_mag[3];
  bit          m_neg[3];
  logic [19:0] p_bcd[3];
  bit          p_ovf[3];
  bit          p_neg[3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_pend[i] <= 1'b0;
        m_age[i]  <= 0;
        p_bcd[i]  <= '0;
        p_ovf[i]  <= 1'b0;
        p_neg[i]  <= 1'b0;
      end else if (!m_pend[i]) begin
        if (iv[i]) begin
          m_pend[i] <= 1'b1;
          m_age[i]  <= 0;
          m_mag[i]  <= magof(bin[i], wof(i));
          m_neg[i]  <= negof(bin[i], wof(i));
        end
      end else if (m_age[i] >= wof(i)) begin
        if (ordy[i]) m_pend[i] <= 1'b0;
      end else begin
        m_age[i] <= m_age[i] + 1;
        if (m_age[i] + 1 == wof(i)) begin
          p_bcd[i] <= to_bcd(m_mag[i], dof(i));
          p_ovf[i] <= (m_mag[i] >= pow10(dof(i)));
          p_neg[i] <= m_neg[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("d%0d in_ready", i), 32'(ir[i]), 32'(!m_pend[i]));
        chk($sformatf("d%0d out_valid", i), 32'(ov[i]), 32'(m_pend[i] && m_age[i] >= wof(i)));
        chk($sformatf("d%0d busy", i), 32'(bz[i]), 32'(m_pend[i]));
        chk($sformatf("d%0d bcd_out", i), 32'(bo[i]), 32'(p_bcd[i]));
        chk($sformatf("d%0d bcd_ovf", i), 32'(ovf[i]), 32'(p_ovf[i]));
        chk($sformatf("d%0d bcd_neg", i), 32'(ng[i]), 32'(p_neg[i]));
      end
    end
  end

  task automatic send(input int id, input logic [15:0] v, input logic [19:0] eb, input logic eo,
                      input logic en, input bit keep, input bit measure, input string nm);
    int n = 0;
    int lat = 0;
    int lowc = 0;
    bit got = 0;
    bin[id] = v;
    iv[id]  = 1'b1;
    while (m_pend[id] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_pend[id]) begin
      chk({nm, " accept timeout"}, 32'(m_pend[id]), 32'd0);
      iv[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!keep) iv[id] = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (!got && ov[id]) begin
        got = 1;
        lat = k;
        chk({nm, " bcd_out"}, 32'(bo[id]), 32'(eb));
        chk({nm, " bcd_ovf"}, 32'(ovf[id]), 32'(eo));
        chk({nm, " bcd_neg"}, 32'(ng[id]), 32'(en));
        if (!measure) break;
      end
      if (measure && ir[id]) begin
        lowc = k;
        break;
      end
    end
    chk({nm, " latency"}, lat, wof(id));
    if (measure) chk({nm, " in_ready low cycles"}, lowc, wof(id) + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; bin[i] = '0; ordy[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset d%0d in_ready", i), 32'(ir[i]), 32'd1);
      chk($sformatf("reset d%0d out_valid", i), 32'(ov[i]), 32'd0);
      chk($sformatf("reset d%0d busy", i), 32'(bz[i]), 32'd0);
      chk($sformatf("reset d%0d bcd_out", i), 32'(bo[i]), 32'd0);
    end

    send(0, 16'd0, 20'h00000, 1'b0, 1'b0, 0, 0, "zero");
`ifdef BIN2BCD_SIGNED_EN
    send(0, 16'hFFFF, 20'h00001, 1'b0, 1'b1, 1, 1, "minus_one_a");
    send(0, 16'hFFFF, 20'h00001, 1'b0, 1'b1, 0, 1, "minus_one_b");
    send(0, 16'h8000, 20'h32768, 1'b0, 1'b1, 0, 0, "most_negative");
    send(0, 16'h7FFF, 20'h32767, 1'b0, 1'b0, 0, 0, "most_positive");
`else
    send(0, 16'd65535, 20'h65535, 1'b0, 1'b0, 1, 1, "max_a");
    send(0, 16'd65535, 20'h65535, 1'b0, 1'b0, 0, 1, "max_b");
`endif

    ordy[0] = 1'b0;
    send(0, 16'd4321, 20'h04321, 1'b0, 1'b0, 0, 0, "hold");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold out_valid", 32'(ov[0]), 32'd1);
      chk("hold in_ready", 32'(ir[0]), 32'd0);
      chk("hold bcd_out", 32'(bo[0]), 32'h04321);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("release in_ready", 32'(ir[0]), 32'd1);
    chk("release out_valid", 32'(ov[0]), 32'd0);
    chk("idle keeps bcd_out", 32'(bo[0]), 32'h04321);

    send(1, 16'd12345, 20'h02345, 1'b1, 1'b0, 0, 0, "trunc_12345");
    send(1, 16'd9999, 20'h09999, 1'b0, 1'b0, 0, 0, "fit_9999");

    bin[0] = 16'd1234;
    iv[0]  = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(ov[0]), 32'd0);
    chk("abort busy", 32'(bz[0]), 32'd0);
    chk("abort in_ready", 32'(ir[0]), 32'd1);
    chk("abort bcd_out", 32'(bo[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("abort no out_valid", 32'(ov[0]), 32'd0);
    end
    send(0, 16'd42, 20'h00042, 1'b0, 1'b0, 0, 0, "after_abort_42");

    for (int i = 0; i < 32; i++) begin
`ifdef BIN2BCD_SIGNED_EN
      int m = (i < 16) ? i : 32 - i;
      send(2, 16'(i), {12'b0, 4'(m / 10), 4'(m % 10)}, 1'b0, (i >= 16), 0, 0, "sweep5");
`else
      send(2, 16'(i), {12'b0, 4'(i / 10), 4'(i % 10)}, 1'b0, 1'b0, 0, 0, "sweep5");
`endif
    end

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
